// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds a small program of instructions and issues them in order to cu
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset (program memory is not reset)
//   i_prog_we      program write strobe, honoured only while idle or done
//   i_prog_addr    program write address
//   i_prog_data    program write data
//   i_start        one-cycle pulse, runs the program from address 0 (idle/done only)
//   o_instr        instruction presented to cu, qualify with o_instr_valid
//   o_instr_valid  o_instr is valid
//   i_instr_ready  downstream accepts o_instr this cycle
//   o_pc           address of the current/last fetched instruction
//   o_busy         high while fetching or issuing
//   o_done         high after the run ends, until the next start
//   o_issue_count  instructions accepted since the last start
module instr_fetch_unit #(
    parameter int IW    = 19,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [IW-1:0] i_prog_data,
    input  logic          i_start,
    output logic [IW-1:0] o_instr,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    output logic [AW-1:0] o_pc,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW:0]   o_issue_count
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;
    state_t        r_state;
    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_instr;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_cnt;
    logic          w_idle;
    logic [IW-1:0] w_word;
    logic          w_halt;

    assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_word = r_mem[r_pc];
    assign w_halt = w_word[IW-1:IW-3] == 3'b000;

    // A write in the same idle cycle as start lands before the first fetch,
    // so address 0 is seen write-first without any bypass.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && w_idle)
            r_mem[i_prog_addr] <= i_prog_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_instr <= w_word;
                    // HALT ends the run here and is never presented downstream.
                    if (w_halt) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_ISSUE;
                        r_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (i_instr_ready) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_valid <= 1'b0;
                        // The last address ends the run; pc never wraps.
                        if (r_pc == LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_FETCH;
                            r_pc    <= r_pc + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_issue_count = r_cnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized run-level reference model checked every cycle against instr_fetch_unit
module tb_instr_fetch_unit;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_prog_we;
    logic [3:0]  i_prog_addr;
    logic [18:0] i_prog_data;
    logic        i_start;
    logic [18:0] o_instr;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [3:0]  o_pc;
    logic        o_busy;
    logic        o_done;
    logic [4:0]  o_issue_count;

    instr_fetch_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
        .i_prog_data(i_prog_data), .i_start(i_start), .o_instr(o_instr),
        .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready), .o_pc(o_pc),
        .o_busy(o_busy), .o_done(o_done), .o_issue_count(o_issue_count)
    );

    int checks = 0;
    int failures = 0;
    bit rnd = 0;
    bit seen_valid = 0;
    logic [18:0] acc_q[$];

    // reference model: a run is the list of words from address 0 up to the first HALT
    logic [18:0] mm [16];
    logic [18:0] run[$];
    bit   m_busy, m_done, m_valid, m_gap;
    int   m_pc, m_cnt;
    logic [18:0] m_instr;

    always #5 i_clk = ~i_clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    initial forever begin
        @(posedge i_clk or negedge i_rst_n);
        if (!i_rst_n) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_gap = 0; m_pc = 0; m_cnt = 0; m_instr = 0;
        end else if (m_busy) begin
            if (m_gap) begin
                m_gap = 0;
                if (m_pc >= run.size()) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_valid = 1; m_instr = run[m_pc];
                end
            end else if (i_instr_ready) begin
                m_cnt++; m_valid = 0;
                if (m_pc == 15) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_pc++; m_gap = 1;
                end
            end
        end else begin
            if (i_prog_we) mm[i_prog_addr] = i_prog_data;
            if (i_start) begin
                run.delete();
                for (int a = 0; a < 16; a++) begin
                    if (mm[a][18:16] == 3'b000) break;
                    run.push_back(mm[a]);
                end
                m_pc = 0; m_cnt = 0; m_done = 0; m_busy = 1; m_gap = 1; m_valid = 0;
            end
        end
    end

    initial forever begin
        @(negedge i_clk);
        if (i_rst_n) begin
            chk("valid", o_instr_valid, m_valid);
            chk("busy", o_busy, m_busy);
            chk("done", o_done, m_done);
            chk("pc", o_pc, m_pc);
            chk("issue_count", o_issue_count, m_cnt);
            if (m_valid) chk("instr", o_instr, m_instr);
        end
    end

    initial forever begin
        @(posedge i_clk);
        if (i_rst_n && o_instr_valid && i_instr_ready) acc_q.push_back(o_instr);
        if (o_instr_valid) seen_valid = 1;
    end

    task automatic load(input int a, input logic [18:0] d);
        i_prog_we = 1; i_prog_addr = 4'(a); i_prog_data = d;
        @(negedge i_clk);
        i_prog_we = 0;
    endtask

    task automatic pulse_start();
        i_start = 1;
        @(negedge i_clk);
        i_start = 0;
    endtask

    task automatic wait_done(input int lim);
        bit ok = 0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge i_clk);
            if (rnd) i_instr_ready = 1'($urandom_range(0, 1));
            ok = o_done;
        end
        chk("done_timeout", 32'(ok), 1);
    endtask

    task automatic wait_valid(input int lim);
        bit ok = o_instr_valid;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge i_clk);
            ok = o_instr_valid;
        end
        chk("valid_timeout", 32'(ok), 1);
    endtask

    function automatic logic [18:0] rword();
        return {3'($urandom_range(1, 7)), 16'($urandom)};
    endfunction

    logic [18:0] t1 [7];
    logic [18:0] p [16];
    logic [18:0] nw;

    initial begin
        t1[0] = 19'b0010010001100010100; t1[1] = {3'd2, 16'h1234}; t1[2] = {3'd3, 16'hbeef};
        t1[3] = {3'd4, 16'h0001}; t1[4] = {3'd5, 16'hffff}; t1[5] = {3'd6, 16'h5a5a}; t1[6] = {3'd7, 16'h8000};
        i_clk = 0; i_rst_n = 0; i_prog_we = 0; i_prog_addr = 0; i_prog_data = 0; i_start = 0; i_instr_ready = 1;
        #3;
        chk("rst_valid", o_instr_valid, 0); chk("rst_instr", o_instr, 0); chk("rst_pc", o_pc, 0);
        chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_count", o_issue_count, 0);
        @(negedge i_clk); #2 i_rst_n = 1;
        @(negedge i_clk);
        // T1: seven instructions then HALT
        for (int i = 0; i < 7; i++) load(i, t1[i]);
        load(7, {3'b000, 16'h1234});
        acc_q.delete();
        pulse_start();
        wait_done(200);
        chk("t1_count", o_issue_count, 7); chk("t1_pc", o_pc, 7); chk("t1_done", o_done, 1);
        chk("t1_accepts", acc_q.size(), 7);
        for (int i = 0; i < 7 && i < acc_q.size(); i++) chk("t1_order", acc_q[i], t1[i]);
        // T2: backpressure holds the first instruction
        i_instr_ready = 0;
        pulse_start();
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("t2_valid", o_instr_valid, 1); chk("t2_instr", o_instr, t1[0]); chk("t2_pc", o_pc, 0);
        end
        i_instr_ready = 1;
        @(negedge i_clk);
        i_instr_ready = 0;
        chk("t2_one_accept", o_issue_count, 1);
        i_instr_ready = 1;
        wait_done(200);
        chk("t2_count", o_issue_count, 7);
        // T3: full memory without HALT
        for (int i = 0; i < 16; i++) begin p[i] = rword(); load(i, p[i]); end
        acc_q.delete(); rnd = 1;
        pulse_start();
        wait_done(600);
        rnd = 0; i_instr_ready = 1;
        repeat (3) @(negedge i_clk);
        chk("t3_count", o_issue_count, 16); chk("t3_pc", o_pc, 15); chk("t3_done", o_done, 1);
        chk("t3_accepts", acc_q.size(), 16);
        if (acc_q.size() == 16) begin chk("t3_first", acc_q[0], p[0]); chk("t3_last", acc_q[15], p[15]); end
        // T4: HALT at address 0
        load(0, {3'b000, 16'($urandom)});
        seen_valid = 0;
        pulse_start();
        chk("t4_busy", o_busy, 1); chk("t4_done_early", o_done, 0);
        @(negedge i_clk);
        chk("t4_done", o_done, 1); chk("t4_busy_end", o_busy, 0);
        chk("t4_no_valid", 32'(seen_valid), 0); chk("t4_count", o_issue_count, 0); chk("t4_pc", o_pc, 0);
        // T5: start and write while busy are ignored
        for (int i = 0; i < 8; i++) begin p[i] = rword(); load(i, p[i]); end
        load(8, 19'h0);
        rnd = 1;
        pulse_start();
        @(negedge i_clk);
        i_start = 1; i_prog_we = 1; i_prog_addr = 3; i_prog_data = rword();
        @(negedge i_clk);
        i_start = 0; i_prog_we = 0;
        wait_done(400);
        acc_q.delete();
        pulse_start();
        wait_done(400);
        chk("t5_accepts", acc_q.size(), 8);
        if (acc_q.size() > 3) chk("t5_mem3", acc_q[3], p[3]);
        // start plus write to address 0 in the same idle cycle
        nw = rword();
        acc_q.delete();
        i_start = 1; i_prog_we = 1; i_prog_addr = 0; i_prog_data = nw;
        @(negedge i_clk);
        i_start = 0; i_prog_we = 0;
        wait_done(400);
        if (acc_q.size() > 0) chk("write_first", acc_q[0], nw);
        // random programs with random HALT position
        for (int r = 0; r < 6; r++) begin
            int h;
            h = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) load(i, (i == h) ? {3'b000, 16'($urandom)} : rword());
            pulse_start();
            wait_done(600);
            chk("rand_count", o_issue_count, h);
            chk("rand_pc", o_pc, (h < 16) ? h : 15);
        end
        // T6: reset mid-ISSUE
        rnd = 0; i_instr_ready = 0;
        pulse_start();
        wait_valid(10);
        @(negedge i_clk);
        #3 i_rst_n = 0;
        #1;
        chk("t6_valid", o_instr_valid, 0); chk("t6_instr", o_instr, 0); chk("t6_pc", o_pc, 0);
        chk("t6_busy", o_busy, 0); chk("t6_done", o_done, 0); chk("t6_count", o_issue_count, 0);
        @(negedge i_clk); #2 i_rst_n = 1;
        i_instr_ready = 1;
        repeat (4) @(negedge i_clk);
        chk("t6_idle_busy", o_busy, 0); chk("t6_idle_done", o_done, 0);
        for (int i = 0; i < 4; i++) load(i, rword());
        load(4, 19'h0);
        pulse_start();
        wait_done(200);
        chk("t6_after_count", o_issue_count, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
